// File: rtl/mc_alu_pkg.sv
// rtl/mc_alu_pkg.sv - op codes and FSM state type shared by the mc_alu slice
package mc_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_REM  = 4'b0111;
  localparam logic [3:0] OP_SHL0 = 4'b1000;
  localparam logic [3:0] OP_SHL1 = 4'b1001;
  localparam logic [3:0] OP_SHLB = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;
  localparam logic [3:0] OP_SHR0 = 4'b1100;
  localparam logic [3:0] OP_SHR1 = 4'b1101;
  localparam logic [3:0] OP_ASR  = 4'b1110;
  localparam logic [3:0] OP_ROR  = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

endpackage

// File: rtl/mc_alu_div.sv
// rtl/mc_alu_div.sv - restoring shift-subtract unsigned divider, one quotient bit per cycle
module mc_alu_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_in, q_in, d_in, r_nx, q_nx;
  logic [WIDTH:0]   trial;

  // One restoring step; the first step runs on the start cycle straight from the operands
  always_comb begin
    r_in  = start ? '0 : remainder;
    q_in  = start ? dividend : quotient;
    d_in  = start ? divisor : d_r;
    trial = {r_in, q_in[WIDTH-1]} - {1'b0, d_in};
    r_nx  = trial[WIDTH] ? {r_in[WIDTH-2:0], q_in[WIDTH-1]} : trial[WIDTH-1:0];
    q_nx  = {q_in[WIDTH-2:0], ~trial[WIDTH]};
  end

  // Step sequencing: WIDTH steps in total, done pulses once the last quotient bit is in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      d_r       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        remainder <= r_nx;
        quotient  <= q_nx;
        d_r       <= divisor;
        cnt       <= CW'(1);
        busy      <= 1'b1;
      end else if (busy) begin
        remainder <= r_nx;
        quotient  <= q_nx;
        cnt       <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU top; MC_ALU_REMAINDER_EN turns op 0111 into unsigned remainder
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             div_zero
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   x_r;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH:0]     mul_sum;

  logic [WIDTH:0]     add_w;
  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] rot_l, rot_r;
  logic [WIDTH-1:0]   fill_lo, fill_hi;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_carry;
  logic               is_divop;
  logic [WIDTH-1:0]   dz_res;

  logic               div_start, div_busy, div_done;
  logic [WIDTH-1:0]   div_q, div_rem;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef MC_ALU_REMAINDER_EN
  assign is_divop = (op == OP_DIV) || (op == OP_REM);
  logic unused_sig;
  assign unused_sig = div_busy;
`else
  assign is_divop = (op == OP_DIV);
  logic unused_sig;
  assign unused_sig = div_busy ^ (^div_rem);
`endif

  assign dz_res    = (op == OP_DIV) ? {WIDTH{1'b1}} : x;
  assign div_start = in_valid && in_ready && is_divop && (y != '0);

  mc_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (x),
    .divisor   (y),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_rem)
  );

  // Shift-add multiplier step: conditionally add multiplicand to upper half, then shift right
  always_comb begin
    mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, x_r} : '0);
    prod_nx = {mul_sum, prod[WIDTH-1:1]};
  end

  // Single-cycle datapath: add/sub/logic and the shifter, evaluated on the accept cycle
  always_comb begin
    add_w    = {1'b0, x} + {1'b0, y};
    amt      = y[SHW-1:0];
    rot_l    = {x, x} << amt;
    rot_r    = {x, x} >> amt;
    fill_lo  = ~({WIDTH{1'b1}} << amt);
    fill_hi  = ~({WIDTH{1'b1}} >> amt);
    sc_res   = '0;
    sc_carry = 1'b0;
    case (op)
      OP_ADD:  begin sc_res = add_w[WIDTH-1:0]; sc_carry = add_w[WIDTH]; end
      OP_SUB:  begin sc_res = x - y; sc_carry = (x < y); end
      OP_AND:  sc_res = x & y;
      OP_OR:   sc_res = x | y;
      OP_XOR:  sc_res = x ^ y;
      OP_SHL0: sc_res = x << amt;
      OP_SHL1: sc_res = (x << amt) | fill_lo;
      OP_SHLB: sc_res = (x << amt) | (x[0] ? fill_lo : '0);
      OP_ROL:  sc_res = rot_l[2*WIDTH-1:WIDTH];
      OP_SHR0: sc_res = x >> amt;
      OP_SHR1: sc_res = (x >> amt) | fill_hi;
      OP_ASR:  sc_res = WIDTH'($signed(x) >>> amt);
      OP_ROR:  sc_res = rot_r[WIDTH-1:0];
      default: sc_res = '0;
    endcase
  end

  // Control FSM with registered result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_r     <= '0;
      x_r      <= '0;
      cnt      <= '0;
      prod     <= '0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r <= op;
            x_r  <= x;
            if (op == OP_MUL) begin
              prod  <= {{WIDTH{1'b0}}, y};
              cnt   <= '0;
              state <= BUSY;
            end else if (is_divop) begin
              if (y == '0) begin
                result   <= dz_res;
                zero     <= (dz_res == '0);
                carry    <= 1'b0;
                div_zero <= 1'b1;
                state    <= DONE;
              end else begin
                state <= BUSY;
              end
            end else begin
              result   <= sc_res;
              zero     <= (sc_res == '0);
              carry    <= sc_carry;
              div_zero <= 1'b0;
              state    <= DONE;
            end
          end
        end
        BUSY: begin
          if (op_r == OP_MUL) begin
            prod <= prod_nx;
            cnt  <= cnt + 1'b1;
            if (cnt == SHW'(WIDTH - 1)) begin
              result   <= prod_nx[WIDTH-1:0];
              zero     <= (prod_nx[WIDTH-1:0] == '0);
              carry    <= |prod_nx[2*WIDTH-1:WIDTH];
              div_zero <= 1'b0;
              state    <= DONE;
            end
          end else if (div_done) begin
            result   <= (op_r == OP_DIV) ? div_q : div_rem;
            zero     <= (((op_r == OP_DIV) ? div_q : div_rem) == '0);
            carry    <= 1'b0;
            div_zero <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// tb/tb_mc_alu.sv - directed self-checking bench for mc_alu at WIDTH=16
module tb_mc_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        zero, carry, div_zero;

  int checks = 0;
  int errors = 0;

  mc_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, measure accept-to-out_valid latency, check outputs, then drain
  task automatic t_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] er, input logic ez,
                      input logic ec, input logic edz, input int elat);
    int lat;
    chk({tag, "_rdy"}, in_ready, 1);
    op = o; x = a; y = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_res"}, result, er);
    chk({tag, "_z"}, zero, ez);
    chk({tag, "_c"}, carry, ec);
    chk({tag, "_dz"}, div_zero, edz);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_flags", {zero, carry, div_zero}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);

    t_op("add_wrap", 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 1);
    t_op("sub_brw",  4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 0, 1, 0, 1);
    t_op("mul_ovf",  4'b0010, 16'h0100, 16'h0100, 16'h0000, 1, 1, 0, 17);
    t_op("mul_ok",   4'b0010, 16'h00FF, 16'h0003, 16'h02FD, 0, 0, 0, 17);
    t_op("div",      4'b0011, 16'd100,  16'd7,    16'd14,   0, 0, 0, 17);
`ifdef MC_ALU_REMAINDER_EN
    t_op("rem",      4'b0111, 16'd100,  16'd7,    16'd2,    0, 0, 0, 17);
`else
    t_op("op7",      4'b0111, 16'd100,  16'd7,    16'd0,    1, 0, 0, 1);
`endif
    t_op("div0",     4'b0011, 16'd5,    16'd0,    16'hFFFF, 0, 0, 1, 1);
    t_op("xor",      4'b0110, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 0, 1);
    t_op("shl1",     4'b1001, 16'h0001, 16'd4,    16'h001F, 0, 0, 0, 1);
    t_op("shlb",     4'b1010, 16'h0003, 16'd3,    16'h001F, 0, 0, 0, 1);
    t_op("rol",      4'b1011, 16'h8001, 16'd1,    16'h0003, 0, 0, 0, 1);
    t_op("shr1",     4'b1101, 16'h0000, 16'd15,   16'hFFFE, 0, 0, 0, 1);
    t_op("ror_wrap", 4'b1111, 16'h0001, 16'd20,   16'h1000, 0, 0, 0, 1);

    // Backpressure: asr result held while out_ready low, second request waits
    op = 4'b1110; x = 16'h8000; y = 16'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'b0000; x = 16'd1; y = 16'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", out_valid, 1);
      chk("bp_res", result, 16'hF800);
      chk("bp_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_ov_drop", out_valid, 0);
    chk("bp_ready_back", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_ov", out_valid, 1);
    chk("bp_second_res", result, 16'd2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in flight during a div
    op = 4'b0011; x = 16'd100; y = 16'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rif_ov", out_valid, 0);
    chk("rif_flags", {zero, carry, div_zero}, 0);
    chk("rif_res", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rif_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rif_no_ov", seen, 0);
    t_op("rif_add", 4'b0000, 16'd2, 16'd3, 16'd5, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits, legal values 8, 16, 32.
REQ-002 SHALL have derived constant SHW = $clog2(WIDTH): the shift-amount width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port op, input, 4 bits: operation code, sampled on accept.
REQ-008 SHALL have ports x and y, input, WIDTH bits each: the operands, sampled on accept.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port result, output, WIDTH bits: the result.
REQ-012 SHALL have flag outputs zero, carry and div_zero, 1 bit each.

Function
REQ-013 SHALL use these op codes: 0000 add, 0001 sub, 0010 mul (low half), 0011 unsigned div, 0100 and, 0101 or, 0110 xor, 0111 rem/none (see REQ-030).
REQ-014 SHALL use these shift op codes: 1000 shl fill-0, 1001 shl fill-1, 1010 shl fill-with-bit0, 1011 rotate-left, 1100 shr fill-0, 1101 shr fill-1, 1110 arithmetic shr, 1111 rotate-right.
REQ-015 SHALL take the shift amount from y[SHW-1:0] only, so the amount wraps modulo WIDTH.
REQ-016 SHALL implement a state machine with states IDLE, BUSY and DONE; in_ready is 1 only in IDLE, and out_valid is 1 only in DONE.
REQ-017 SHALL accept a request when in_valid & in_ready; x, y and op are latched into internal registers on accept.
REQ-018 SHALL, for single-cycle ops (add, sub, logic, shifts, rem-disabled 0111), go IDLE->DONE on accept, with out_valid high the next cycle.
REQ-019 SHALL, for mul, div and rem, go IDLE->BUSY, iterate one bit per cycle for exactly WIDTH cycles, then enter DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-020 SHALL, for div/rem with y==0, skip BUSY and go directly to DONE: result = all-ones for div, x for rem, div_zero=1.
REQ-021 SHALL go DONE->IDLE when out_ready is high; result and flags hold stable while out_valid & ~out_ready.
REQ-022 SHALL ignore in_valid outside IDLE, with no queueing; a new accept is possible in the cycle after DONE exits.
REQ-023 SHALL set zero = (result == 0) for every op.
REQ-024 SHALL set carry as follows: add gives the carry-out; sub gives the borrow (x < y); mul gives 1 when the upper product half is nonzero; all other ops give 0.
REQ-025 SHALL set div_zero to 0 for every op other than div/rem with y==0.

Reset
REQ-026 SHALL, on rst_n low, immediately force state=IDLE, out_valid=0, result=0, zero=0, carry=0, div_zero=0, and clear the iteration counter.
REQ-027 SHALL drive in_ready=1 in the first clock after rst_n deasserts.
REQ-028 SHALL, on reset during BUSY or DONE, discard the operation with no later out_valid for it.

Configuration
REQ-029 SHALL support the macro MC_ALU_REMAINDER_EN.
REQ-030 SHALL, with MC_ALU_REMAINDER_EN defined, make op 0111 the unsigned remainder x % y, using the divider with div latency; without it, op 0111 is single-cycle with result=0, zero=1 and no divider remainder register.

Structure
REQ-031 SHALL place the op-code localparams and the state enum typedef in package mc_alu_pkg.
REQ-032 SHALL place the restoring shift-subtract divider in sub-module mc_alu_div, with WIDTH parameter, start/busy/done, and quotient/remainder outputs.
REQ-033 SHALL implement the shift-add multiplier and the shifter inline in mc_alu.

Verification
REQ-034 SHALL cover add with WIDTH=16: 0xFFFF+0x0001 -> result 0x0000, zero=1, carry=1, out_valid 1 cycle after accept.
REQ-035 SHALL cover mul: 0x0100*0x0100 -> result 0x0000, carry=1, zero=1, out_valid 17 cycles after accept; 0x00FF*0x0003 -> 0x02FD, carry=0.
REQ-036 SHALL cover div: 100/7 -> result 14; with MC_ALU_REMAINDER_EN, op 0111 on 100,7 -> result 2; both at 17 cycles latency.
REQ-037 SHALL cover divide by zero: div 5/0 -> result 0xFFFF, div_zero=1, out_valid 1 cycle after accept.
REQ-038 SHALL cover backpressure: arithmetic shr of 0x8000 by 4 with out_ready low for 5 cycles -> result 0xF800 held stable, in_ready=0, and a second in_valid not accepted until one cycle after out_ready.
REQ-039 SHALL cover reset in flight: rst_n pulsed low 8 cycles into a div -> out_valid stays 0, flags 0, in_ready=1 after release, and the next add completes correctly.
